// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } arb_state_e;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_MAX_BURST  = 4;

    // Width of a producer index.
    function automatic int unsigned id_width(input int unsigned num_req);
        return $clog2(num_req);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Cyclic first-one finder: lowest set request at or after ptr_i, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N = DEF_NUM_REQ,
    parameter int unsigned W = id_width(DEF_NUM_REQ)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         hit_o,
    output logic [W-1:0] idx_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W:0]     off;
    logic [W:0]     sum;
    logic           found;

    // Rotate so ptr_i lands at bit 0, find first one, then map back to an absolute index.
    always_comb begin
        dbl   = {req_i, req_i} >> ptr_i;
        rot   = dbl[N-1:0];
        found = 1'b0;
        off   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = (W+1)'(i);
            end
        end
        sum = {1'b0, ptr_i} + off;
        if (sum >= (W+1)'(N)) begin
            sum = sum - (W+1)'(N);
        end
        hit_o = found;
        idx_o = sum[W-1:0];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a sync_fifo write port.
// Optional build macro FIFO_ARB_TAG_EN prepends the owner ID to the write data.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MAX_BURST  = DEF_MAX_BURST,
    localparam int unsigned ID_W      = id_width(NUM_REQ),
`ifdef FIFO_ARB_TAG_EN
    localparam int unsigned OUT_W     = DATA_WIDTH + ID_W
`else
    localparam int unsigned OUT_W     = DATA_WIDTH
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wr_en_o,
    output logic [OUT_W-1:0]              fifo_wr_data_o,
    output logic [ID_W-1:0]               grant_id_o,
    output logic                          busy_o
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e            state_q, state_d;
    logic [ID_W-1:0]       own_q, own_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  pick_hit;
    logic [ID_W-1:0]       pick_idx;
    logic                  own_valid;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  granted;
    logic                  accept;
    logic                  last_beat;

    rr_pick #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_pick (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .hit_o (pick_hit),
        .idx_o (pick_idx)
    );

    // Select the current owner's valid bit and data slice.
    always_comb begin
        own_valid = 1'b0;
        own_data  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (own_q == ID_W'(k)) begin
                own_valid = req_valid_i[k];
                own_data  = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign granted   = (state_q == ST_GRANT);
    assign accept    = granted && own_valid && !fifo_full_i;
    assign last_beat = (cnt_q == CNT_W'(MAX_BURST - 1));

    // Handshake and FIFO write outputs, combinational from state, owner, valid and full.
    always_comb begin
        req_ready_o = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (own_q == ID_W'(k)) begin
                req_ready_o[k] = accept;
            end
        end
        fifo_wr_en_o   = accept;
        busy_o         = granted;
        grant_id_o     = own_q;
        fifo_wr_data_o = '0;
        if (granted) begin
`ifdef FIFO_ARB_TAG_EN
            fifo_wr_data_o = {own_q, own_data};
`else
            fifo_wr_data_o = own_data;
`endif
        end
    end

    // Next-state: arbitrate in IDLE; count beats and release on burst end or producer running dry.
    always_comb begin
        state_d  = state_q;
        own_d    = own_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_hit) begin
                    state_d = ST_GRANT;
                    own_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (!own_valid || (accept && last_beat)) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (own_q == ID_W'(NUM_REQ - 1)) ? '0 : own_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            own_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            own_q    <= own_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with a cycle-level reference model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 4;
    localparam int IW = $clog2(N);
`ifdef FIFO_ARB_TAG_EN
    localparam int OW = DW + IW;
`else
    localparam int OW = DW;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid_i = '0;
    logic [N*DW-1:0] req_data_i = '0;
    logic [N-1:0]    req_ready_o;
    logic            fifo_full_i = 1'b0;
    logic            fifo_wr_en_o;
    logic [OW-1:0]   fifo_wr_data_o;
    logic [IW-1:0]   grant_id_o;
    logic            busy_o;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_data_i     (req_data_i),
        .req_ready_o    (req_ready_o),
        .fifo_full_i    (fifo_full_i),
        .fifo_wr_en_o   (fifo_wr_en_o),
        .fifo_wr_data_o (fifo_wr_data_o),
        .grant_id_o     (grant_id_o),
        .busy_o         (busy_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        bit           busy;
        int           gid;
        logic [N-1:0] ready;
        bit           wr;
    } cyc_t;

    int checks   = 0;
    int failures = 0;

    cyc_t          cycq[$];
    logic [OW-1:0] wq[$];
    int            glog[$];
    int            wr_count = 0;
    logic [OW-1:0] last_wr = '0;

    // producers
    bit            vld[N];
    logic [DW-1:0] dat[N];
    int            left[N];
    int            act_pct   = 100;
    bit            rand_full = 0;
    bit            full_cmd  = 0;
    bit            force_en  = 0;
    logic [DW-1:0] force_val = '0;

    // reference arbiter model
    bit m_busy  = 0;
    int m_own   = 0;
    int m_beats = 0;
    int m_ptr   = 0;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endfunction

    function automatic int gl(input int i);
        if (i < glog.size()) return glog[i];
        return -1;
    endfunction

    function automatic void clear_producers();
        for (int k = 0; k < N; k++) begin
            vld[k]  = 0;
            left[k] = 0;
            dat[k]  = '0;
        end
        force_en  = 0;
        act_pct   = 100;
        rand_full = 0;
        full_cmd  = 0;
    endfunction

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // One clock of stimulus: drive producers, predict the cycle's outputs, advance the model.
    task automatic step();
        bit   full_now;
        bit   acc;
        bit   found;
        int   c;
        cyc_t rec;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (!vld[k] && left[k] > 0 && $urandom_range(0, 99) < act_pct) begin
                vld[k] = 1;
                dat[k] = force_en ? force_val : DW'($urandom);
            end
        end
        full_now = rand_full ? ($urandom_range(0, 3) == 0) : full_cmd;
        for (int k = 0; k < N; k++) begin
            req_valid_i[k]          = vld[k];
            req_data_i[k*DW +: DW]  = dat[k];
        end
        fifo_full_i = full_now;

        rec.busy  = m_busy;
        rec.gid   = m_own;
        rec.ready = '0;
        rec.wr    = 0;
        if (!m_busy) begin
            found = 0;
            for (int i = 0; i < N; i++) begin
                c = (m_ptr + i) % N;
                if (!found && vld[c]) begin
                    found   = 1;
                    m_busy  = 1;
                    m_own   = c;
                    m_beats = 0;
                end
            end
        end else begin
            acc = vld[m_own] && !full_now;
            rec.ready[m_own] = acc;
            rec.wr = acc;
            if (acc) begin
`ifdef FIFO_ARB_TAG_EN
                wq.push_back({IW'(m_own), dat[m_own]});
`else
                wq.push_back(dat[m_own]);
`endif
                m_beats++;
            end
            if (!vld[m_own] || (acc && m_beats == MB)) begin
                m_busy = 0;
                m_ptr  = (m_own + 1) % N;
            end
            if (acc) begin
                vld[m_own] = 0;
                left[m_own]--;
            end
        end
        cycq.push_back(rec);
    endtask

    // Asynchronous reset asserted between clock edges; optionally checks outputs clear at once.
    task automatic do_reset(input bit chk_en);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        if (chk_en) begin
            chk("rst_wr_en", 64'(fifo_wr_en_o), 64'(0));
            chk("rst_ready", 64'(req_ready_o), 64'(0));
            chk("rst_busy", 64'(busy_o), 64'(0));
            chk("rst_gid", 64'(grant_id_o), 64'(0));
            chk("rst_data", 64'(fifo_wr_data_o), 64'(0));
        end
        req_valid_i = '0;
        wq.delete();
        cycq.delete();
        m_busy  = 0;
        m_own   = 0;
        m_beats = 0;
        m_ptr   = 0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    // Monitor: per-cycle status and write-data scoreboard.
    initial begin
        cyc_t r;
        bit   prev_busy;
        prev_busy = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 0;
            end else begin
                if (cycq.size() > 0) begin
                    r = cycq.pop_front();
                    chk("busy", 64'(busy_o), 64'(r.busy));
                    chk("wr_en", 64'(fifo_wr_en_o), 64'(r.wr));
                    chk("ready", 64'(req_ready_o), 64'(r.ready));
                    if (r.busy) chk("grant_id", 64'(grant_id_o), 64'(r.gid));
                end
                if (fifo_wr_en_o) begin
                    wr_count++;
                    last_wr = fifo_wr_data_o;
                    if (wq.size() == 0) chk("wr_without_expect", 64'(fifo_wr_en_o), 64'(0));
                    else chk("wr_data", 64'(fifo_wr_data_o), 64'(wq.pop_front()));
                end
                if (busy_o && !prev_busy) glog.push_back(int'(grant_id_o));
                prev_busy = busy_o;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            base;
        int            n;
        logic [OW-1:0] tag_exp;
        bit            busy_any;

        clear_producers();
        do_reset(1);

        // single producer, continuous valid
        clear_producers();
        left[0] = 8;
        glog.delete();
        base = wr_count;
        repeat (11) step();
        settle();
        chk("t1_writes", 64'(wr_count - base), 64'(8));
        chk("t1_grants", 64'(glog.size()), 64'(2));
        chk("t1_g0", 64'(gl(0)), 64'(0));
        chk("t1_g1", 64'(gl(1)), 64'(0));

        // all producers continuous
        do_reset(0);
        clear_producers();
        for (int k = 0; k < N; k++) left[k] = 100;
        glog.delete();
        base = wr_count;
        repeat (26) step();
        settle();
        chk("t2_g0", 64'(gl(0)), 64'(0));
        chk("t2_g1", 64'(gl(1)), 64'(1));
        chk("t2_g2", 64'(gl(2)), 64'(2));
        chk("t2_g3", 64'(gl(3)), 64'(3));
        chk("t2_g4", 64'(gl(4)), 64'(0));
        chk("t2_writes", 64'(wr_count - base), 64'(20));

        // owner 2 runs dry after two words
        do_reset(0);
        clear_producers();
        left[2] = 2;
        left[3] = 4;
        glog.delete();
        repeat (14) step();
        settle();
        chk("t3_g0", 64'(gl(0)), 64'(2));
        chk("t3_g1", 64'(gl(1)), 64'(3));

        // FIFO full for 5 cycles after beat 2
        do_reset(0);
        clear_producers();
        left[0] = 4;
        base = wr_count;
        repeat (3) step();
        full_cmd = 1;
        repeat (5) step();
        settle();
        chk("t4_stall_writes", 64'(wr_count - base), 64'(2));
        chk("t4_stall_busy", 64'(busy_o), 64'(1));
        chk("t4_stall_wr_en", 64'(fifo_wr_en_o), 64'(0));
        full_cmd = 0;
        repeat (6) step();
        settle();
        chk("t4_writes", 64'(wr_count - base), 64'(4));

        // async reset mid-burst, pointer must restart at 0
        do_reset(0);
        clear_producers();
        left[1] = 1;
        repeat (4) step();
        left[3] = 4;
        repeat (2) step();
        left[1] = 2;
        step();
        do_reset(1);
        glog.delete();
        repeat (24) step();
        settle();
        chk("t5_first_grant", 64'(gl(0)), 64'(1));

        // tagged / untagged data format
        do_reset(0);
        clear_producers();
        force_en  = 1;
        force_val = 16'hABCD;
        left[3]   = 1;
        last_wr   = '0;
        repeat (4) step();
        settle();
`ifdef FIFO_ARB_TAG_EN
        tag_exp = {IW'(3), 16'hABCD};
`else
        tag_exp = 16'hABCD;
`endif
        chk("t6_data", 64'(last_wr), 64'(tag_exp));

        // randomized traffic with random back-pressure
        do_reset(0);
        clear_producers();
        act_pct   = 50;
        rand_full = 1;
        repeat (1500) begin
            for (int k = 0; k < N; k++) begin
                if (left[k] == 0 && $urandom_range(0, 9) == 0) left[k] = $urandom_range(1, 12);
            end
            step();
        end
        rand_full = 0;
        act_pct   = 100;
        n = 0;
        busy_any = 1;
        while (busy_any && n < 400) begin
            step();
            n++;
            busy_any = m_busy;
            for (int k = 0; k < N; k++) if (left[k] > 0 || vld[k]) busy_any = 1;
        end
        if (busy_any) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d exp=<400", n);
        end
        step();
        settle();
        chk("t7_leftover", 64'(wq.size()), 64'(0));
        chk("t7_idle", 64'(busy_o), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
